// File: rtl/shared_op_scheduler_if.sv
// rtl/shared_op_scheduler_if.sv - requester-side bundle of the shared operator scheduler
interface shared_op_scheduler_if #(
  parameter int data_width = 32,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ-1:0]              ack;
  logic [2*data_width*NUM_REQ-1:0] din;
  logic [data_width-1:0]           dout;
  logic [ID_W-1:0]                 gnt_id;
  logic                            busy;

  modport master (output req, din, input ack, dout, gnt_id, busy);
  modport slave  (input req, din, output ack, dout, gnt_id, busy);
endinterface

// File: rtl/shared_op_scheduler.sv
// rtl/shared_op_scheduler.sv - round-robin time-multiplexing of one mul/add/sub unit
module shared_op_scheduler #(
  parameter int    data_width = 32,
  parameter int    NUM_REQ    = 4,
  parameter string op         = "mul",
  parameter int    LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  shared_op_scheduler_if.slave  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_nxt;
  logic [ID_W-1:0]       ptr, gnt_r, pick;
  logic [NUM_REQ-1:0]    holdoff, eligible;
  logic [data_width-1:0] op_a, op_b, dout_r, result;
  logic [CNT_W-1:0]      cnt;
  logic                  found, grant;
  int                    rr_idx;

  // First eligible requester at or after ptr, wrapping around.
  always_comb begin
    eligible = bus.req & ~holdoff;
    found    = 1'b0;
    pick     = '0;
    rr_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && eligible[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx[ID_W-1:0];
      end
    end
  end

  if (op == "add") begin : g_add
    assign result = op_a + op_b;
  end else if (op == "sub") begin : g_sub
    assign result = op_a - op_b;
  end else begin : g_mul
    assign result = op_a * op_b;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    bus.ack   = '0;
    bus.busy  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        bus.busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.ack   = NUM_REQ'(1) << gnt_r;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_r   <= '0;
      holdoff <= '0;
      op_a    <= '0;
      op_b    <= '0;
      cnt     <= '0;
      dout_r  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          // The mask only covers the first IDLE cycle after an ack.
          holdoff <= '0;
          if (grant) begin
            op_a  <= bus.din[2*data_width*int'(pick) +: data_width];
            op_b  <= bus.din[2*data_width*int'(pick) + data_width +: data_width];
            gnt_r <= pick;
            cnt   <= CNT_W'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt == '0) dout_r <= result;
          else           cnt    <= cnt - CNT_W'(1);
        end
        DONE: begin
          ptr     <= (gnt_r == ID_W'(NUM_REQ - 1)) ? '0 : gnt_r + ID_W'(1);
          holdoff <= NUM_REQ'(1) << gnt_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.dout   = dout_r;
  assign bus.gnt_id = gnt_r;
endmodule

// File: tb/tb_shared_op_scheduler.sv
// tb/tb_shared_op_scheduler.sv - scoreboard bench for mul, add and sub scheduler instances
module tb_shared_op_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          id;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  shared_op_scheduler_if #(.data_width(32), .NUM_REQ(4)) m_if ();
  shared_op_scheduler_if #(.data_width(32), .NUM_REQ(4)) a_if ();
  shared_op_scheduler_if #(.data_width(32), .NUM_REQ(4)) s_if ();

  shared_op_scheduler #(.data_width(32), .NUM_REQ(4), .op("mul"), .LATENCY(2))
    u_mul (.clk(clk), .rst(rst), .bus(m_if.slave));
  shared_op_scheduler #(.data_width(32), .NUM_REQ(4), .op("add"), .LATENCY(2))
    u_add (.clk(clk), .rst(rst), .bus(a_if.slave));
  shared_op_scheduler #(.data_width(32), .NUM_REQ(4), .op("sub"), .LATENCY(2))
    u_sub (.clk(clk), .rst(rst), .bus(s_if.slave));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for an ack on instance which (0 mul, 1 add, 2 sub); the requester
  // keeps req through the first IDLE edge after the ack, then drops it.
  task automatic serve_one(input int which, output logic [3:0] o_ack,
                           output logic [31:0] o_dout, output int o_cyc, output bit o_ok);
    logic [3:0]  a;
    logic [31:0] d;
    o_ok = 1'b0; o_ack = '0; o_dout = '0; o_cyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      case (which)
        0:       begin a = m_if.ack; d = m_if.dout; end
        1:       begin a = a_if.ack; d = a_if.dout; end
        default: begin a = s_if.ack; d = s_if.dout; end
      endcase
      if (a != 4'b0) begin
        o_ok = 1'b1; o_ack = a; o_dout = d; o_cyc = cyc;
        break;
      end
    end
    if (o_ok) begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      case (which)
        0:       m_if.req = m_if.req & ~o_ack;
        1:       a_if.req = a_if.req & ~o_ack;
        default: s_if.req = s_if.req & ~o_ack;
      endcase
    end
  endtask

  task automatic test_reset;
    m_if.req = '0; a_if.req = '0; s_if.req = '0;
    m_if.din = '0; a_if.din = '0; s_if.din = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_if.ack, m_if.busy, m_if.gnt_id, m_if.dout} !== '0) begin
      errors++; $display("FAIL reset_mul: ack=%b busy=%b gnt=%0d dout=%h required all zero",
                         m_if.ack, m_if.busy, m_if.gnt_id, m_if.dout);
    end
    checks++;
    if ({a_if.ack, a_if.busy, a_if.gnt_id, a_if.dout, s_if.ack, s_if.busy, s_if.gnt_id, s_if.dout} !== '0) begin
      errors++; $display("FAIL reset_add_sub: add ack=%b dout=%h sub ack=%b dout=%h required zero",
                         a_if.ack, a_if.dout, s_if.ack, s_if.dout);
    end
    rst = 1'b1;
  endtask

  task automatic test_single;
    exp_t e;
    @(negedge clk);
    m_if.din[128 +: 32] = 32'd7;
    m_if.din[160 +: 32] = 32'd6;
    m_if.req = 4'b0100;
    exp_q.push_back('{2, 32'd42});
    @(posedge clk); #1;
    checks++;
    if (m_if.busy !== 1'b1 || m_if.gnt_id !== 2'd2 || m_if.ack !== 4'b0) begin
      errors++; $display("FAIL single_grant: busy=%b gnt=%0d ack=%b required busy=1 gnt=2 ack=0",
                         m_if.busy, m_if.gnt_id, m_if.ack);
    end
    @(posedge clk); #1;
    checks++;
    if (m_if.ack !== 4'b0) begin
      errors++; $display("FAIL single_early_ack: ack=%b required 0000", m_if.ack);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (m_if.ack !== (4'b1 << e.id) || m_if.dout !== e.val || m_if.gnt_id !== 2'd2) begin
      errors++; $display("FAIL single_result: ack=%b dout=%0d gnt=%0d required ack=%b dout=%0d gnt=2",
                         m_if.ack, m_if.dout, m_if.gnt_id, 4'b1 << e.id, e.val);
    end
    m_if.req = '0;
    @(posedge clk); #1;
    checks++;
    if (m_if.ack !== 4'b0 || m_if.busy !== 1'b0 || m_if.dout !== 32'd42) begin
      errors++; $display("FAIL single_after: ack=%b busy=%b dout=%0d required 0000 0 42",
                         m_if.ack, m_if.busy, m_if.dout);
    end
  endtask

  task automatic test_contention;
    logic [3:0]  ack_v;
    logic [31:0] dout_v;
    int          t, prev;
    bit          ok;
    exp_t        e;
    prev = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a_if.din[64*i +: 32]      = 32'(i);
      a_if.din[64*i + 32 +: 32] = 32'd10;
      exp_q.push_back('{i, 32'(10 + i)});
    end
    a_if.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      serve_one(1, ack_v, dout_v, t, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
        errors++; $display("FAIL contention_ack_%0d: no ack within bound", i);
      end else begin
        e = exp_q.pop_front();
        if (ack_v !== (4'b1 << e.id) || dout_v !== e.val) begin
          errors++; $display("FAIL contention_result_%0d: ack=%b dout=%0d required ack=%b dout=%0d",
                             i, ack_v, dout_v, 4'b1 << e.id, e.val);
        end
        if (i > 0) begin
          checks++;
          if (t - prev !== 4) begin
            errors++; $display("FAIL contention_period_%0d: %0d cycles required 4", i, t - prev);
          end
        end
        prev = t;
      end
    end
  endtask

  task automatic test_holdoff;
    logic [3:0]  ack_v, seen;
    logic [31:0] dout_v;
    int          t;
    bit          ok;
    exp_t        e;
    @(negedge clk);
    m_if.din[192 +: 32] = 32'd3;
    m_if.din[224 +: 32] = 32'd3;
    m_if.req = 4'b1000;
    exp_q.push_back('{3, 32'd9});
    serve_one(0, ack_v, dout_v, t, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || ack_v !== (4'b1 << e.id) || dout_v !== e.val) begin
      errors++; $display("FAIL wrap_first: ok=%0d ack=%b dout=%0d required ack=%b dout=%0d",
                         ok, ack_v, dout_v, 4'b1 << e.id, e.val);
    end
    checks++;
    if (m_if.busy !== 1'b0) begin
      errors++; $display("FAIL holdoff_stale: busy=%b required 0 after stale req", m_if.busy);
    end
    seen = '0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | m_if.ack;
    end
    checks++;
    if (seen !== 4'b0) begin
      errors++; $display("FAIL holdoff_no_reack: ack=%b required 0000", seen);
    end
    m_if.din[0 +: 32]   = 32'd2;
    m_if.din[32 +: 32]  = 32'd5;
    m_if.din[192 +: 32] = 32'd4;
    m_if.din[224 +: 32] = 32'd4;
    m_if.req = 4'b1001;
    exp_q.push_back('{0, 32'd10});
    exp_q.push_back('{3, 32'd16});
    repeat (2) begin
      serve_one(0, ack_v, dout_v, t, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || ack_v !== (4'b1 << e.id) || dout_v !== e.val) begin
        errors++; $display("FAIL wrap_order: ok=%0d ack=%b dout=%0d required ack=%b dout=%0d",
                           ok, ack_v, dout_v, 4'b1 << e.id, e.val);
      end
    end
  endtask

  task automatic test_truncation;
    logic [3:0]  ack_v;
    logic [31:0] dout_v;
    int          t;
    bit          ok;
    exp_t        e;
    @(negedge clk);
    m_if.din[64 +: 32] = 32'hFFFF_FFFF;
    m_if.din[96 +: 32] = 32'd2;
    m_if.req = 4'b0010;
    s_if.din[0 +: 32]  = 32'd3;
    s_if.din[32 +: 32] = 32'd5;
    s_if.req = 4'b0001;
    exp_q.push_back('{1, 32'hFFFF_FFFE});
    exp_q.push_back('{0, 32'hFFFF_FFFE});
    serve_one(0, ack_v, dout_v, t, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || ack_v !== (4'b1 << e.id) || dout_v !== e.val) begin
      errors++; $display("FAIL trunc_mul: ok=%0d ack=%b dout=%h required ack=%b dout=%h",
                         ok, ack_v, dout_v, 4'b1 << e.id, e.val);
    end
    serve_one(2, ack_v, dout_v, t, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || ack_v !== (4'b1 << e.id) || dout_v !== e.val) begin
      errors++; $display("FAIL trunc_sub: ok=%0d ack=%b dout=%h required ack=%b dout=%h",
                         ok, ack_v, dout_v, 4'b1 << e.id, e.val);
    end
  endtask

  task automatic test_operand_stability;
    logic [3:0]  ack_v;
    logic [31:0] dout_v;
    int          t;
    bit          ok;
    exp_t        e;
    @(negedge clk);
    m_if.din[128 +: 32] = 32'd5;
    m_if.din[160 +: 32] = 32'd9;
    m_if.req = 4'b0100;
    exp_q.push_back('{2, 32'd45});
    @(posedge clk);
    @(negedge clk);
    m_if.din[128 +: 32] = 32'd100;
    m_if.din[160 +: 32] = 32'd100;
    serve_one(0, ack_v, dout_v, t, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || ack_v !== (4'b1 << e.id) || dout_v !== e.val) begin
      errors++; $display("FAIL operand_stability: ok=%0d ack=%b dout=%0d required ack=%b dout=%0d",
                         ok, ack_v, dout_v, 4'b1 << e.id, e.val);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [3:0]  ack_v, seen;
    logic [31:0] dout_v;
    int          t;
    bit          ok, busy_seen;
    exp_t        e;
    @(negedge clk);
    m_if.din[64 +: 32] = 32'd6;
    m_if.din[96 +: 32] = 32'd7;
    m_if.req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_if.busy !== 1'b1 || m_if.gnt_id !== 2'd1) begin
      errors++; $display("FAIL midop_grant: busy=%b gnt=%0d required 1 1", m_if.busy, m_if.gnt_id);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (m_if.ack !== 4'b0 || m_if.busy !== 1'b0 || m_if.dout !== 32'd0 || m_if.gnt_id !== 2'd0) begin
      errors++; $display("FAIL midop_reset: ack=%b busy=%b dout=%0d gnt=%0d required all zero",
                         m_if.ack, m_if.busy, m_if.dout, m_if.gnt_id);
    end
    m_if.req = '0;
    @(negedge clk);
    rst = 1'b1;
    seen = '0;
    busy_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | m_if.ack;
      busy_seen = busy_seen | m_if.busy;
    end
    checks++;
    if (seen !== 4'b0 || busy_seen !== 1'b0) begin
      errors++; $display("FAIL midop_dropped: ack=%b busy=%b required 0000 0", seen, busy_seen);
    end
    m_if.din[0 +: 32]   = 32'd4;
    m_if.din[32 +: 32]  = 32'd4;
    m_if.din[192 +: 32] = 32'd3;
    m_if.din[224 +: 32] = 32'd7;
    m_if.req = 4'b1001;
    exp_q.push_back('{0, 32'd16});
    exp_q.push_back('{3, 32'd21});
    repeat (2) begin
      serve_one(0, ack_v, dout_v, t, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || ack_v !== (4'b1 << e.id) || dout_v !== e.val) begin
        errors++; $display("FAIL midop_ptr_reset: ok=%0d ack=%b dout=%0d required ack=%b dout=%0d",
                           ok, ack_v, dout_v, 4'b1 << e.id, e.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_holdoff();
    test_truncation();
    test_operand_stability();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
